// File: rtl/code_prefetch_queue.sv
// Code prefetch queue: requests aligned dwords from the BIU code port, buffers
// them in a small FIFO and hands the instruction stream to the decoder one byte
// per cycle. A flush redirects fetching and drops any fetch still on the bus.
module code_prefetch_queue #(
  parameter int          DEPTH         = 4,
  parameter logic [31:0] RESET_ADDRESS = 32'hFFFF_FFF0
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic [31:0] i_flush_address,
  output logic        o_code_vaild,
  input  logic        i_code_ready,
  output logic [31:0] o_code_address,
  input  logic [31:0] i_code_data_read,
  output logic        o_byte_vaild,
  input  logic        i_byte_ready,
  output logic [7:0]  o_byte,
  output logic [31:0] o_byte_address
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t            state;
  logic [31:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [1:0]        offset;
  logic [29:0]       fetch_dw;
  logic [31:0]       byte_address;
  logic [31:0]       head;
  logic              push;
  logic              pop;
  logic              consume;

  // The BIU re-samples valid during its ready pulse, so valid is masked there
  // to avoid a second fetch of the same dword.
  assign o_code_vaild   = (state == FETCH) & ~i_code_ready;
  assign o_code_address = {fetch_dw, 2'b00};
  assign o_byte_vaild   = (count != '0) & ~i_flush;
  assign o_byte_address = byte_address;

  assign consume = o_byte_vaild & i_byte_ready;
  assign pop     = consume & (offset == 2'd3);
  assign push    = (state == FETCH) & i_code_ready & ~i_flush;
  assign head    = mem[rd_ptr];

  // Little-endian byte lane select from the head dword.
  always_comb begin
    o_byte = head[7:0];
    case (offset)
      2'd0: o_byte = head[7:0];
      2'd1: o_byte = head[15:8];
      2'd2: o_byte = head[23:16];
      2'd3: o_byte = head[31:24];
      default: o_byte = head[7:0];
    endcase
  end

  // Dword storage; contents need no reset because count gates every read.
  always_ff @(posedge i_clock) begin
    if (push) begin
      mem[wr_ptr] <= i_code_data_read;
    end
  end

  // Fetch sequencing, FIFO bookkeeping and byte pointer; flush overrides all.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      offset       <= RESET_ADDRESS[1:0];
      fetch_dw     <= RESET_ADDRESS[31:2];
      byte_address <= RESET_ADDRESS;
    end else if (i_flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      offset       <= i_flush_address[1:0];
      fetch_dw     <= i_flush_address[31:2];
      byte_address <= i_flush_address;
      case (state)
        FETCH:   state <= i_code_ready ? IDLE : DISCARD;
        DISCARD: state <= i_code_ready ? IDLE : DISCARD;
        default: state <= IDLE;
      endcase
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (consume) begin
        offset       <= offset + 2'd1;
        byte_address <= byte_address + 32'd1;
      end
      case (state)
        IDLE: begin
          if (count < DEPTH_C) begin
            state <= FETCH;
          end
        end
        FETCH: begin
          if (i_code_ready) begin
            fetch_dw <= fetch_dw + 30'd1;
            state    <= IDLE;
          end
        end
        DISCARD: begin
          if (i_code_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
